// File: rtl/regfile_pkg.sv
// Shared defaults, select-width helper and select type for the register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned NREGS_DEF = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int unsigned SELW_DEF = clog2(NREGS_DEF);

  typedef logic [SELW_DEF-1:0] reg_sel_t;

endpackage

// File: rtl/regfile_sb_bits.sv
// Per-register busy flags (issue sets, flush/writeback clear) and the registered WAW error pulse.
module regfile_sb_bits
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned SELW    = clog2(NREGS),
  parameter int unsigned R0_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issueEn,
  input  logic [SELW-1:0]  issueRegSel,
  input  logic             writeEn,
  input  logic [SELW-1:0]  writeRegSel,
  input  logic             flush,
  output logic [NREGS-1:0] busyVec,
  output logic             err
);

  logic [NREGS-1:0] r_busy;
  logic             r_err;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_err_nxt;
  logic             w_is_r0;

  assign w_is_r0 = (R0_ZERO != 0) && (issueRegSel == '0);

  // Issue beats flush, flush beats writeback; hardwired r0 never goes busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < int'(NREGS); r++) begin
      if ((R0_ZERO != 0) && (r == 0)) begin
        w_busy_nxt[r] = 1'b0;
      end else if (issueEn && (issueRegSel == SELW'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (flush) begin
        w_busy_nxt[r] = 1'b0;
      end else if (writeEn && (writeRegSel == SELW'(r))) begin
        w_busy_nxt[r] = 1'b0;
      end
    end
  end

  assign w_err_nxt = issueEn && r_busy[issueRegSel]
                     && !(writeEn && (writeRegSel == issueRegSel))
                     && !flush && !w_is_r0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign busyVec = r_busy;
  assign err     = r_err;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (1W/2R combinational) with busy scoreboard for decode hazard detection.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned SELW    = clog2(NREGS),
  parameter int unsigned R0_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1RegSel,
  input  logic [SELW-1:0]  read2RegSel,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             read1Busy,
  output logic             read2Busy,
  input  logic [SELW-1:0]  writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  input  logic             issueEn,
  input  logic [SELW-1:0]  issueRegSel,
  input  logic             flush,
  output logic [NREGS-1:0] busyVec,
  output logic             err
);

  logic [NREGS-1:0][WIDTH-1:0] w_rows;

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_row
    if ((R0_ZERO != 0) && (g == 0)) begin : g_zero
      assign w_rows[g] = '0;
    end else begin : g_dff
      logic [WIDTH-1:0] r_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
        end else if (writeEn && (writeRegSel == SELW'(g))) begin
          r_data <= writeData;
        end
      end
      assign w_rows[g] = r_data;
    end
  end

  regfile_sb_bits #(
    .NREGS   (NREGS),
    .SELW    (SELW),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issueEn     (issueEn),
    .issueRegSel (issueRegSel),
    .writeEn     (writeEn),
    .writeRegSel (writeRegSel),
    .flush       (flush),
    .busyVec     (busyVec),
    .err         (err)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Forward in-flight writeback to a matching reader, never for hardwired r0.
  assign w_byp1 = writeEn && (writeRegSel == read1RegSel)
                  && !((R0_ZERO != 0) && (read1RegSel == '0));
  assign w_byp2 = writeEn && (writeRegSel == read2RegSel)
                  && !((R0_ZERO != 0) && (read2RegSel == '0));

  assign read1Data = w_byp1 ? writeData : w_rows[read1RegSel];
  assign read2Data = w_byp2 ? writeData : w_rows[read2RegSel];
  assign read1Busy = busyVec[read1RegSel] && !w_byp1;
  assign read2Busy = busyVec[read2RegSel] && !w_byp2;
`else
  assign read1Data = w_rows[read1RegSel];
  assign read2Data = w_rows[read2RegSel];
  assign read1Busy = busyVec[read1RegSel];
  assign read2Busy = busyVec[read2RegSel];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: stimulus queues expected values, a negedge monitor pops and compares.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  reg_sel_t    read1RegSel, read2RegSel, writeRegSel, issueRegSel;
  logic [15:0] writeData;
  logic        writeEn, issueEn, flush;

  logic [15:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic        rb1_a, rb2_a, rb1_z, rb2_z;
  logic [7:0]  bv_a, bv_z;
  logic        err_a, err_z;

  always #5 clk = ~clk;

  regfile_scoreboard #(.WIDTH(16), .NREGS(8), .SELW(3), .R0_ZERO(0)) dut (
    .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(rd1_a), .read2Data(rd2_a), .read1Busy(rb1_a), .read2Busy(rb2_a),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .issueEn(issueEn), .issueRegSel(issueRegSel), .flush(flush),
    .busyVec(bv_a), .err(err_a));

  regfile_scoreboard #(.WIDTH(16), .NREGS(8), .SELW(3), .R0_ZERO(1)) dut0 (
    .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
    .read1Data(rd1_z), .read2Data(rd2_z), .read1Busy(rb1_z), .read2Busy(rb2_z),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .issueEn(issueEn), .issueRegSel(issueRegSel), .flush(flush),
    .busyVec(bv_z), .err(err_z));

  typedef enum int {K_RD1, K_RD2, K_RB1, K_RB2, K_BV, K_ERR,
                    K_RD1_Z, K_BV_Z, K_ERR_Z} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic expect_val(input string n, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.exp = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input kind_t k);
    case (k)
      K_RD1:   return 32'(rd1_a);
      K_RD2:   return 32'(rd2_a);
      K_RB1:   return 32'(rb1_a);
      K_RB2:   return 32'(rb2_a);
      K_BV:    return 32'(bv_a);
      K_ERR:   return 32'(err_a);
      K_RD1_Z: return 32'(rd1_z);
      K_BV_Z:  return 32'(bv_z);
      default: return 32'(err_z);
    endcase
  endfunction

  // Monitor: drain all expectations queued during this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.kind);
      n_checks++;
      if (a !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    read1RegSel = '0; read2RegSel = '0; writeRegSel = '0; issueRegSel = '0;
    writeData = '0; writeEn = 1'b0; issueEn = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state on both ports
    for (int r = 0; r < 8; r++) begin
      read1RegSel = reg_sel_t'(r);
      read2RegSel = reg_sel_t'(7 - r);
      expect_val($sformatf("reset_rd1_r%0d", r), K_RD1, 32'h0);
      expect_val($sformatf("reset_rd2_r%0d", 7 - r), K_RD2, 32'h0);
      if (r == 0) begin
        expect_val("reset_busyvec", K_BV, 32'h0);
        expect_val("reset_err", K_ERR, 32'h0);
      end
      step();
    end

    // Write r3=ABCD
    writeEn = 1'b1; writeRegSel = 3'd3; writeData = 16'hABCD; read1RegSel = 3'd3;
    expect_val("wr_r3_same_cycle", K_RD1, BYP ? 32'hABCD : 32'h0);
    expect_val("wr_r3_busy_same_cycle", K_RB1, 32'h0);
    step();
    writeEn = 1'b0;
    expect_val("wr_r3_next_cycle", K_RD1, 32'hABCD);
    step();

    // Issue r5 then writeback 1234
    issueEn = 1'b1; issueRegSel = 3'd5;
    step();
    issueEn = 1'b0; read1RegSel = 3'd5;
    expect_val("iss_r5_busyvec", K_BV, 32'h20);
    expect_val("iss_r5_rd1busy", K_RB1, 32'h1);
    step();
    writeEn = 1'b1; writeRegSel = 3'd5; writeData = 16'h1234;
    expect_val("wb_r5_busyvec_pre", K_BV, 32'h20);
    expect_val("wb_r5_rd1busy_pre", K_RB1, BYP ? 32'h0 : 32'h1);
    step();
    writeEn = 1'b0;
    expect_val("wb_r5_busyvec", K_BV, 32'h0);
    expect_val("wb_r5_data", K_RD1, 32'h1234);
    expect_val("wb_r5_err", K_ERR, 32'h0);
    step();

    // Double issue r2 -> WAW err pulse
    issueEn = 1'b1; issueRegSel = 3'd2;
    step();
    read2RegSel = 3'd2;
    expect_val("iss_r2_first_err", K_ERR, 32'h0);
    expect_val("iss_r2_rd2busy", K_RB2, 32'h1);
    step();
    issueEn = 1'b0;
    expect_val("waw_r2_err", K_ERR, 32'h1);
    expect_val("waw_r2_busyvec", K_BV, 32'h04);
    step();
    expect_val("waw_r2_err_drop", K_ERR, 32'h0);
    issueEn = 1'b1; issueRegSel = 3'd2;
    writeEn = 1'b1; writeRegSel = 3'd2; writeData = 16'h5555;
    step();
    issueEn = 1'b0; writeEn = 1'b0;
    expect_val("iss_wr_r2_err", K_ERR, 32'h0);
    expect_val("iss_wr_r2_busyvec", K_BV, 32'h04);
    expect_val("iss_wr_r2_data", K_RD2, 32'h5555);
    step();

    // Issue r1, r4, then flush + issue r6
    issueEn = 1'b1; issueRegSel = 3'd1;
    step();
    issueRegSel = 3'd4;
    step();
    expect_val("iss_r1_r4_busyvec", K_BV, 32'h16);
    issueRegSel = 3'd6; flush = 1'b1;
    step();
    issueEn = 1'b0; flush = 1'b0;
    expect_val("flush_iss_r6_busyvec", K_BV, 32'h40);
    expect_val("flush_iss_r6_err", K_ERR, 32'h0);
    step();
    writeEn = 1'b1; writeRegSel = 3'd1; writeData = 16'h00FF;
    step();
    writeEn = 1'b0; read1RegSel = 3'd1;
    expect_val("straggler_r1_data", K_RD1, 32'h00FF);
    expect_val("straggler_r1_err", K_ERR, 32'h0);
    expect_val("straggler_busyvec", K_BV, 32'h40);
    step();

    // r0: hardwired in dut0, ordinary in dut
    issueEn = 1'b1; issueRegSel = 3'd0;
    writeEn = 1'b1; writeRegSel = 3'd0; writeData = 16'hFFFF;
    step();
    writeEn = 1'b0;
    step();
    issueEn = 1'b0; read1RegSel = 3'd0;
    expect_val("r0z_data", K_RD1_Z, 32'h0);
    expect_val("r0z_busyvec", K_BV_Z, 32'h40);
    expect_val("r0z_err", K_ERR_Z, 32'h0);
    expect_val("r0_plain_data", K_RD1, 32'hFFFF);
    expect_val("r0_plain_busyvec", K_BV, 32'h41);
    expect_val("r0_plain_err", K_ERR, 32'h1);
    step();

    // Mid-cycle async reset
    read1RegSel = 3'd3;
    #2 rst = 1'b1;
    expect_val("midrst_rd1", K_RD1, 32'h0);
    expect_val("midrst_busyvec", K_BV, 32'h0);
    expect_val("midrst_busyvec_z", K_BV_Z, 32'h0);
    expect_val("midrst_err", K_ERR, 32'h0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
